// File: rtl/mux_sweep_ctrl.sv
// Sweep sequencer for a 2**SEL_W-lane read mux: steps sel from first_sel to last_sel (wrapping)
// and streams {index, lane value} over valid/ready. Define SWEEP_SKIP_ZERO_EN to suppress zero-valued lanes.
module mux_sweep_ctrl #(
  parameter int SEL_W  = 8,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [SEL_W-1:0]  first_sel,
  input  logic [SEL_W-1:0]  last_sel,
  output logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] mux_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SEL_W-1:0]  out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state_reg, state_next;
  logic [SEL_W-1:0]    sel_reg, sel_next;
  logic [SEL_W-1:0]    last_reg, last_next;
  logic                out_valid_reg, out_valid_next;
  logic [SEL_W-1:0]    out_idx_reg, out_idx_next;
  logic [DATA_W-1:0]   out_data_reg, out_data_next;
  logic                done_reg, done_next;
  logic                load;

  // The output register can take a new element when empty or being drained this cycle.
  assign load = !out_valid_reg || out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      sel_reg       <= '0;
      last_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_idx_reg   <= '0;
      out_data_reg  <= '0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      last_reg      <= last_next;
      out_valid_reg <= out_valid_next;
      out_idx_reg   <= out_idx_next;
      out_data_reg  <= out_data_next;
      done_reg      <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    last_next      = last_reg;
    out_valid_next = out_valid_reg;
    out_idx_next   = out_idx_reg;
    out_data_next  = out_data_reg;
    done_next      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          sel_next   = first_sel;
          last_next  = last_sel;
          state_next = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end else if (load) begin
`ifdef SWEEP_SKIP_ZERO_EN
          // A zero lane still consumes a step but presents nothing.
          if (mux_out == '0) begin
            out_valid_next = 1'b0;
          end else begin
            out_valid_next = 1'b1;
            out_idx_next   = sel_reg;
            out_data_next  = mux_out;
          end
`else
          out_valid_next = 1'b1;
          out_idx_next   = sel_reg;
          out_data_next  = mux_out;
`endif
          if (sel_reg == last_reg) begin
            state_next = DRAIN;
          end else begin
            sel_next = sel_reg + SEL_W'(1);
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          out_valid_next = 1'b0;
          state_next     = IDLE;
        end else if (load) begin
          out_valid_next = 1'b0;
          done_next      = 1'b1;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign sel       = sel_reg;
  assign out_valid = out_valid_reg;
  assign out_idx   = out_idx_reg;
  assign out_data  = out_data_reg;
  assign done      = done_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_mux_sweep_ctrl.sv
// Scoreboard bench for mux_sweep_ctrl: expected {idx,data} pushed per sweep, monitor pops on handshakes.
module tb_mux_sweep_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] first_sel = '0;
  logic [7:0] last_sel = '0;
  logic [7:0] sel;
  logic [3:0] mux_out;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_idx;
  logic [3:0] out_data;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_count = 0;
  int exp_done = 0;
  int last_hs_cyc = 0;
  bit hs_seen = 0;
  bit rand_ready = 0;
  bit stall_pending = 0;
  logic [7:0] held_idx;
  logic [3:0] held_data;
  logic [11:0] exp_q[$];

  mux_sweep_ctrl #(.SEL_W(8), .DATA_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .first_sel(first_sel), .last_sel(last_sel), .sel(sel), .mux_out(mux_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_data(out_data), .busy(busy), .done(done)
  );

  assign mux_out = sel[3:0] ^ sel[7:4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: consumes expected elements on every accepted handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_pending = 0;
    end else begin
      if (stall_pending)
        check(out_valid && out_idx == held_idx && out_data == held_data, "stall_stable",
              {out_valid, out_idx, out_data}, {1'b1, held_idx, held_data});
      if (out_valid && out_ready && !abort) begin
        if (exp_q.size() == 0) begin
          check(0, "unexpected_elem", {out_idx, out_data}, 0);
        end else begin
          logic [11:0] e;
          e = exp_q.pop_front();
          check({out_idx, out_data} == e, "elem", {out_idx, out_data}, e);
        end
        last_hs_cyc = cyc;
        hs_seen = 1;
      end
      if (done) begin
        done_count++;
        check(!out_valid, "done_no_valid", out_valid, 0);
`ifdef SWEEP_SKIP_ZERO_EN
        if (hs_seen) check(cyc - last_hs_cyc <= 2, "done_latency", cyc - last_hs_cyc, 2);
`else
        if (hs_seen) check(cyc - last_hs_cyc == 1, "done_latency", cyc - last_hs_cyc, 1);
`endif
      end
      stall_pending = out_valid && !out_ready && !abort;
      held_idx  = out_idx;
      held_data = out_data;
    end
  end

  // Reference: walk the range with modular arithmetic and apply the lane formula.
  task automatic push_expected(input logic [7:0] f, input logic [7:0] l);
    int n;
    logic [7:0] idx;
    logic [3:0] d;
    n = ((int'(l) - int'(f) + 256) % 256) + 1;
    for (int i = 0; i < n; i++) begin
      idx = 8'((int'(f) + i) % 256);
      d = idx[3:0] ^ idx[7:4];
`ifdef SWEEP_SKIP_ZERO_EN
      if (d != 0) exp_q.push_back({idx, d});
`else
      exp_q.push_back({idx, d});
`endif
    end
  endtask

  task automatic run_sweep(input logic [7:0] f, input logic [7:0] l, input bit chk_lat,
                           input bit poke_start);
    int t;
    push_expected(f, l);
    exp_done++;
    hs_seen = 0;
    @(posedge clk); #1;
    first_sel = f; last_sel = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; first_sel = 8'($urandom); last_sel = 8'($urandom);
    if (chk_lat) begin
      check(busy && !out_valid, "lat_cycle1", {busy, out_valid}, 2);
      @(posedge clk); #1;
      check(out_valid && out_idx == f, "lat_first_valid", {out_valid, out_idx}, {1'b1, f});
    end
    if (poke_start) begin
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    t = 0;
    while (done_count < exp_done && t < 3000) begin
      @(posedge clk); t++;
    end
    #1;
    check(done_count == exp_done, "done_count", done_count, exp_done);
    check(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);
    check(!busy, "idle_after_done", busy, 0);
    exp_q.delete();
  endtask

  initial begin
    #22;
    check({sel, out_valid, out_idx, out_data, busy, done} == 0, "reset_state",
          {sel, out_valid, out_idx, out_data, busy, done}, 0);
    @(negedge clk); rst_n = 1'b1;

    run_sweep(8'h10, 8'h13, 1, 0);          // T1 / T6
    run_sweep(8'hFE, 8'h01, 0, 0);          // T2 wrap
    run_sweep(8'h05, 8'h04, 0, 1);          // T3 full range, start poked while busy
    rand_ready = 1;
    run_sweep(8'h10, 8'h13, 0, 0);          // T4 stalls
    for (int k = 0; k < 6; k++) begin
      logic [7:0] f;
      f = 8'($urandom);
      run_sweep(f, f + 8'($urandom_range(0, 23)), 0, 0);
    end
    run_sweep(8'h42, 8'h42, 0, 0);          // single element
    rand_ready = 0;

    // T5: abort while the third element is presented.
    begin
      int t;
      push_expected(8'h30, 8'h3F);
      @(posedge clk); #1;
      first_sel = 8'h30; last_sel = 8'h3F; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      t = 0;
      while (!(out_valid && out_idx == 8'h32) && t < 50) begin
        @(posedge clk); #1; t++;
      end
      check(t < 50, "abort_reach", t, 0);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check(!out_valid && !busy, "abort_idle", {out_valid, busy}, 0);
      check(sel == 8'h33, "abort_sel_hold", sel, 8'h33);
      check(exp_q.size() == 14, "abort_popped", exp_q.size(), 14);
      exp_q.delete();
      repeat (5) @(posedge clk);
      #1;
      check(done_count == exp_done, "abort_no_done", done_count, exp_done);
    end
    run_sweep(8'h80, 8'h87, 0, 0);          // normal run after abort

    // Asynchronous reset mid-sweep.
    push_expected(8'h20, 8'h60);
    @(posedge clk); #1;
    first_sel = 8'h20; last_sel = 8'h60; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check({sel, out_valid, out_idx, out_data, busy, done} == 0, "async_reset",
          {sel, out_valid, out_idx, out_data, busy, done}, 0);
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    run_sweep(8'hFF, 8'h02, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
